// File: rtl/bmem_responder.sv
// Burst memory responder: accepts 4-beat line writes and queues line reads,
// returning each as 4 registered beats a fixed LATENCY after acceptance.
module bmem_responder #(
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 4,
    parameter int QDEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bmem_addr,
    input  logic        bmem_read,
    input  logic        bmem_write,
    input  logic [63:0] bmem_wdata,
    output logic        bmem_ready,
    output logic [31:0] bmem_raddr,
    output logic [63:0] bmem_rdata,
    output logic        bmem_rvalid,
    output logic        err
);
    typedef enum logic {W_IDLE, W_BURST} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;

    localparam int               PTR_W       = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PTR_W:0]   FIFO_FULL   = (PTR_W+1)'(QDEPTH);
    localparam logic [PTR_W:0]   FIFO_ONE    = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(QDEPTH - 1);
    localparam logic [3:0]       WAIT_REFILL = 4'(LATENCY - 1);
    // From idle the acceptance edge itself already counts as one wait cycle.
    localparam logic [3:0]       WAIT_FIRST  = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    logic [63:0]          mem    [2**ADDR_BITS];
    logic [26:0]          fifo_q [QDEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PTR_W:0]       count;
    w_state_t             w_state, w_state_nxt;
    r_state_t             r_state, r_state_nxt;
    logic [1:0]           wbeat, wbeat_nxt, rbeat, rbeat_nxt, load_k;
    logic [26:0]          wline, wline_nxt, head_line, rd_line;
    logic [3:0]           cnt, cnt_nxt;
    logic                 proto_err, rd_ok, wr_ok, push, pop, wr_acc, load_beat;
    logic                 fifo_empty, fifo_full;
    logic [ADDR_BITS-1:0] wr_idx, rd_idx;
    logic                 unused_addr_lsbs;

    function automatic logic [ADDR_BITS-1:0] word_idx(input logic [26:0] line, input logic [1:0] k);
        return ADDR_BITS'({line, k});
    endfunction

    assign unused_addr_lsbs = ^bmem_addr[4:0];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FIFO_FULL);
    assign head_line  = fifo_q[rd_ptr];
    assign proto_err  = bmem_read & bmem_write;
    assign rd_ok      = !fifo_full && (w_state == W_IDLE);
    // A new write waits until every queued read has drained, so reads never see later data.
    assign wr_ok      = (w_state == W_BURST) || (fifo_empty && (r_state == R_IDLE));
    assign push       = bmem_read & ~bmem_write & rd_ok;
    assign wr_acc     = bmem_write & ~bmem_read & wr_ok;
    assign bmem_ready = rst & ~proto_err & (bmem_write ? wr_ok : rd_ok);
    assign wr_idx     = word_idx((w_state == W_IDLE) ? bmem_addr[31:5] : wline, wbeat);
    assign rd_idx     = word_idx(rd_line, load_k);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = w_state;
        wbeat_nxt   = wbeat;
        wline_nxt   = wline;
        if (wr_acc) begin
            wbeat_nxt = wbeat + 2'd1;
            case (w_state)
                W_IDLE: begin
                    w_state_nxt = W_BURST;
                    wline_nxt   = bmem_addr[31:5];
                end
                W_BURST: if (wbeat == 2'd3) w_state_nxt = W_IDLE;
                default: ;
            endcase
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        cnt_nxt     = cnt;
        rbeat_nxt   = rbeat;
        pop         = 1'b0;
        load_beat   = 1'b0;
        load_k      = 2'd0;
        rd_line     = head_line;
        case (r_state)
            R_IDLE: if (push) begin
                if (LATENCY == 1) begin
                    r_state_nxt = R_BURST;
                    load_beat   = 1'b1;
                    rbeat_nxt   = 2'd0;
                    rd_line     = bmem_addr[31:5];
                end else begin
                    r_state_nxt = R_WAIT;
                    cnt_nxt     = WAIT_FIRST;
                end
            end
            R_WAIT: if (cnt == 4'd0) begin
                r_state_nxt = R_BURST;
                load_beat   = 1'b1;
                rbeat_nxt   = 2'd0;
            end else begin
                cnt_nxt = cnt - 4'd1;
            end
            R_BURST: if (rbeat == 2'd3) begin
                pop = 1'b1;
                if (count > FIFO_ONE || push) begin
                    r_state_nxt = R_WAIT;
                    cnt_nxt     = WAIT_REFILL;
                end else begin
                    r_state_nxt = R_IDLE;
                end
            end else begin
                load_beat = 1'b1;
                load_k    = rbeat + 2'd1;
                rbeat_nxt = rbeat + 2'd1;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state     <= W_IDLE;
            r_state     <= R_IDLE;
            wbeat       <= 2'd0;
            wline       <= '0;
            rbeat       <= 2'd0;
            cnt         <= 4'd0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            err         <= 1'b0;
            bmem_rvalid <= 1'b0;
            bmem_raddr  <= '0;
            bmem_rdata  <= '0;
        end else begin
            w_state <= w_state_nxt;
            r_state <= r_state_nxt;
            wbeat   <= wbeat_nxt;
            wline   <= wline_nxt;
            rbeat   <= rbeat_nxt;
            cnt     <= cnt_nxt;
            err     <= err | proto_err;
            if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (load_beat) begin
                bmem_rvalid <= 1'b1;
                bmem_rdata  <= mem[rd_idx];
                bmem_raddr  <= {rd_line, 5'b0};
            end else begin
                bmem_rvalid <= 1'b0;
            end
        end
    end

    // NOTE: storage arrays carry no reset; contents must survive rst and map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_idx] <= bmem_wdata;
        if (push)   fifo_q[wr_ptr] <= bmem_addr[31:5];
    end
endmodule
